// File: rtl/sgde_pkg.sv
// Shared constants and the scanout state type for the frame-buffer scanout slice.
// Geometry is fixed at 64x64 pixels of 12-bit RGB 4:4:4.
package sgde_pkg;

  localparam int FB_DIM = 64;
  localparam int FB_AW  = 12;
  localparam int PIX_W  = 12;

  localparam logic [PIX_W-1:0] BG_COLOR = 12'hCF0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/fb_rd_fifo.sv
// Two-entry FIFO holding frame-buffer read data together with its {y,x} tag.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module fb_rd_fifo
  import sgde_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic [FB_AW-1:0] push_tag,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [PIX_W-1:0] head_data,
  output logic [FB_AW-1:0] head_tag
);

  logic [PIX_W-1:0] data_q [2];
  logic [FB_AW-1:0] tag_q  [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        tag_q[wr_ptr]  <= push_tag;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_tag  = tag_q[rd_ptr];

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: reads NUM_LINES x 64 pixels from a 1-cycle-latency SRAM
// and streams them out with ready/valid flow control, coordinates and sof/eol.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_SCAN  | issuing frame-buffer reads, throttled by FIFO space and line gap
// ST_DRAIN | all reads issued, waiting for the last beat to transfer
// ST_DONE  | frame delivered, done held until the next start
module fb_scanout
  import sgde_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int LINE_GAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_ready,
  input  logic [PIX_W-1:0] FB_Q,
  output logic             FB_CEN,
  output logic             FB_WEN,
  output logic [FB_AW-1:0] FB_A,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic [5:0]       pix_x,
  output logic [5:0]       pix_y,
  output logic             sof,
  output logic             eol,
  output logic             busy,
  output logic             done
);

  localparam logic [FB_AW-1:0] LAST_A = FB_AW'(NUM_LINES * FB_DIM - 1);
  localparam logic [3:0]       GAP_LD = 4'(LINE_GAP);
  localparam logic [5:0]       X_LAST = 6'(FB_DIM - 1);

  scan_state_t      state, state_nxt;
  logic [FB_AW-1:0] addr_cnt;
  logic [3:0]       gap_cnt;
  logic             rd_pend;
  logic [FB_AW-1:0] rd_tag;
  logic [1:0]       fifo_count;
  logic [FB_AW-1:0] head_tag;
  logic [2:0]       occ_after;
  logic             issue;
  logic             pop;
  logic             start_ok;

  assign pix_valid = (fifo_count != 2'd0);
  assign pop       = pix_valid && pix_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Space is judged after this cycle's pop so a steady stream runs at one pixel per cycle.
  assign occ_after = {1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, pop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if ((gap_cnt == 4'd0) && (occ_after < 3'd2)) begin
          issue = 1'b1;
          if (addr_cnt == LAST_A) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (fifo_count == 2'd1) && !rd_pend) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_cnt <= '0;
      gap_cnt  <= 4'd0;
      rd_pend  <= 1'b0;
      rd_tag   <= '0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        rd_tag <= addr_cnt;
      end
      if (start_ok) begin
        addr_cnt <= '0;
        gap_cnt  <= 4'd0;
      end else if (issue) begin
        // The counter parks on the last address so it never wraps inside a frame.
        if (addr_cnt != LAST_A) begin
          addr_cnt <= addr_cnt + 1'b1;
          if (addr_cnt[5:0] == X_LAST) begin
            gap_cnt <= GAP_LD;
          end
        end
      end else if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  fb_rd_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend),
    .push_data (FB_Q),
    .push_tag  (rd_tag),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (pix_data),
    .head_tag  (head_tag)
  );

  assign FB_CEN = ~issue;
  assign FB_WEN = 1'b1;
  assign FB_A   = addr_cnt;

  assign pix_x = head_tag[5:0];
  assign pix_y = head_tag[11:6];
  assign sof   = pix_valid && (head_tag == '0);
  assign eol   = pix_valid && (head_tag[5:0] == X_LAST);
  assign busy  = (state == ST_SCAN) || (state == ST_DRAIN);
  assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a full-size instance and a 2-line/3-gap instance share one
// frame-buffer image; beats are checked against the expected raster order.
module tb_fb_scanout;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_a, ready_a, cen_a, wen_a, valid_a, sof_a, eol_a, busy_a, done_a;
  logic [11:0] q_a, a_a, data_a;
  logic [5:0]  x_a, y_a;
  logic        start_b, ready_b, cen_b, wen_b, valid_b, sof_b, eol_b, busy_b, done_b;
  logic [11:0] q_b, a_b, data_b;
  logic [5:0]  x_b, y_b;

  logic [11:0] mem [4096];
  int          issue_cyc [4096];
  int          n_cmp = 0;
  int          n_bad = 0;

  fb_scanout dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pix_ready(ready_a), .FB_Q(q_a),
    .FB_CEN(cen_a), .FB_WEN(wen_a), .FB_A(a_a), .pix_valid(valid_a), .pix_data(data_a),
    .pix_x(x_a), .pix_y(y_a), .sof(sof_a), .eol(eol_a), .busy(busy_a), .done(done_a)
  );

  fb_scanout #(.NUM_LINES(2), .LINE_GAP(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pix_ready(ready_b), .FB_Q(q_b),
    .FB_CEN(cen_b), .FB_WEN(wen_b), .FB_A(a_b), .pix_valid(valid_b), .pix_data(data_b),
    .pix_x(x_b), .pix_y(y_b), .sof(sof_b), .eol(eol_b), .busy(busy_b), .done(done_b)
  );

  // Synchronous SRAM: data valid one cycle after the address edge.
  always @(posedge clk) if (!cen_a) q_a <= mem[a_a];
  always @(posedge clk) if (!cen_b) q_b <= mem[a_b];

  logic        sel;
  logic        v_cen, v_valid, v_sof, v_eol, v_busy, v_done, v_ready;
  logic [11:0] v_a, v_data;
  logic [5:0]  v_x, v_y;
  always_comb begin
    v_cen   = sel ? cen_b   : cen_a;
    v_valid = sel ? valid_b : valid_a;
    v_sof   = sel ? sof_b   : sof_a;
    v_eol   = sel ? eol_b   : eol_a;
    v_busy  = sel ? busy_b  : busy_a;
    v_done  = sel ? done_b  : done_a;
    v_ready = sel ? ready_b : ready_a;
    v_a     = sel ? a_b     : a_a;
    v_data  = sel ? data_b  : data_a;
    v_x     = sel ? x_b     : x_a;
    v_y     = sel ? y_b     : y_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit st, input bit rdy);
    start_a = !sel && st;
    ready_a = !sel && rdy;
    start_b = sel && st;
    ready_b = sel && rdy;
  endtask

  // 0: always ready, 1: toggling, 2: random, 3: held off for 20 cycles
  function automatic bit rdy_of(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      2:       return $urandom_range(3) != 0;
      default: return cyc >= 20;
    endcase
  endfunction

  task automatic run_frame(input bit s, input int mode, input int poke, input int abort_beat,
                           input int exp_last_cyc);
    int nb, idx, issued, first_v, last_cyc;
    bit stalled;
    logic [11:0] pd;
    logic [5:0]  px, py;
    logic        psof, peol;
    nb = s ? 128 : 4096;
    idx = 0; issued = 0; first_v = -1; last_cyc = -1; stalled = 0;
    pd = '0; px = '0; py = '0; psof = 0; peol = 0;
    @(negedge clk);
    sel = s;
    drive(1'b1, 1'b1);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      drive(cyc == poke, rdy_of(mode, cyc));
      #1;
      if (cyc == 0) begin
        chk("done_cleared", 32'(v_done), 0);
        chk("busy_on", 32'(v_busy), 1);
      end
      if (stalled) begin
        chk("hold_valid", 32'(v_valid), 1);
        chk("hold_data", 32'(v_data), 32'(pd));
        chk("hold_xy", {20'd0, v_y, v_x}, {20'd0, py, px});
        chk("hold_flags", {30'd0, v_sof, v_eol}, {30'd0, psof, peol});
      end
      if (v_valid && first_v < 0) first_v = cyc;
      if (!v_cen) begin
        chk("rd_addr", 32'(v_a), 32'(issued));
        issue_cyc[issued] = cyc;
        issued++;
      end
      if (mode == 3 && cyc == 19) begin
        chk("stall_reads", 32'(issued), 2);
        chk("stall_valid", 32'(v_valid), 1);
        chk("stall_data", 32'(v_data), 32'(mem[0]));
      end
      if (v_valid && v_ready) begin
        chk("beat_data", 32'(v_data), 32'(mem[idx]));
        chk("beat_x", 32'(v_x), 32'(idx % 64));
        chk("beat_y", 32'(v_y), 32'(idx / 64));
        chk("beat_sof", 32'(v_sof), 32'(idx == 0));
        chk("beat_eol", 32'(v_eol), 32'((idx % 64) == 63));
        idx++;
      end
      chk("outstanding", 32'((issued - idx) <= 2), 1);
      stalled = v_valid && !v_ready;
      pd = v_data; px = v_x; py = v_y; psof = v_sof; peol = v_eol;
      if (idx == abort_beat) return;
      if (idx == nb) begin
        last_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b1);
    #1;
    chk("done_set", 32'(v_done), 1);
    chk("busy_off", 32'(v_busy), 0);
    chk("beat_count", 32'(idx), 32'(nb));
    chk("read_count", 32'(issued), 32'(nb));
    chk("first_valid", 32'(first_v), 2);
    if (exp_last_cyc > 0) chk("last_beat_cyc", 32'(last_cyc), 32'(exp_last_cyc));
  endtask

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    drive(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cen", 32'(cen_a), 1);
    chk("rst_wen", 32'(wen_a), 1);
    chk("rst_addr", 32'(a_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_xy", {20'd0, y_a, x_a}, 0);
    chk("rst_flags", {28'd0, sof_a, eol_a, busy_a, done_a}, 0);
    chk("rst_b_cen", {30'd0, cen_b, wen_b}, 3);
    @(negedge clk);
    reset = 1'b0;

    // Identity image at full rate: one beat per cycle, done right after beat 4095.
    for (int i = 0; i < 4096; i++) mem[i] = 12'(i);
    run_frame(1'b0, 0, -1, -1, 4097);

    // Random image with toggling, held-off and random ready; a stray start mid-scan.
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    run_frame(1'b0, 1, -1, -1, 0);
    run_frame(1'b0, 3, -1, -1, 0);
    run_frame(1'b0, 2, 500, -1, 0);

    // Two lines with a three-cycle gap after x=63.
    run_frame(1'b1, 0, -1, -1, 132);
    chk("gap_in_line", 32'(issue_cyc[63] - issue_cyc[62]), 1);
    chk("gap_after_eol", 32'(issue_cyc[64] - issue_cyc[63]), 4);
    chk("gap_restart", 32'(issue_cyc[65] - issue_cyc[64]), 1);

    // Reset in the middle of a frame, then a clean restart.
    run_frame(1'b0, 2, -1, 1000, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("abort_valid", 32'(valid_a), 0);
    chk("abort_cen", 32'(cen_a), 1);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_addr", 32'(a_a), 0);
    reset = 1'b0;
    run_frame(1'b0, 0, -1, -1, 4097);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter NUM_LINES, default 64, number of 64-pixel lines read per frame (1..64).
REQ-002 Parameter LINE_GAP, default 0, idle cycles inserted after the read of the last pixel of each line (0..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  frame request pulse, sampled on clk rising edge.
REQ-006 pix_ready  input  1  downstream accepts the current pixel.
REQ-007 FB_Q  input  12  frame-buffer read data, valid one cycle after the address edge.
REQ-008 FB_CEN  output  1  frame-buffer chip enable, active-low.
REQ-009 FB_WEN  output  1  frame-buffer write enable, active-low; tied 1 (read-only).
REQ-010 FB_A  output  12  frame-buffer address {y[5:0], x[5:0]}.
REQ-011 pix_valid  output  1  pixel beat present.
REQ-012 pix_data  output  12  pixel colour (RGB 4:4:4).
REQ-013 pix_x, pix_y  output  6 each  coordinates of the current beat.
REQ-014 sof  output  1  beat is x=0, y=0.
REQ-015 eol  output  1  beat is x=63.
REQ-016 busy  output  1  high in SCAN or DRAIN.
REQ-017 done  output  1  frame fully delivered; held until next accepted start.

Function
REQ-018 FSM states: IDLE, SCAN, DRAIN, DONE.
REQ-019 IDLE/DONE + start=1 -> SCAN: read address counter set to 0, done cleared on that same edge.
REQ-020 start while busy is ignored.
REQ-021 In SCAN, a read (FB_CEN=0, FB_A=counter) is issued in a cycle only when FIFO occupancy plus in-flight reads < 2 and no line gap is pending; otherwise FB_CEN=1.
REQ-022 Counter increments by 1 per issued read; after x=63 is issued, LINE_GAP cycles with FB_CEN=1 follow.
REQ-023 Issue of address NUM_LINES*64-1 -> DRAIN.
REQ-024 Read data is pushed, with its {y,x} tag, into a 2-entry FIFO on the edge after issue; the FIFO never overflows.
REQ-025 pix_valid = FIFO not empty; pix_data/pix_x/pix_y/sof/eol come from the FIFO head.
REQ-026 A beat transfers when pix_valid && pix_ready; while pix_valid && !pix_ready, all pix_* outputs are held stable.
REQ-027 With pix_ready=1 and LINE_GAP=0, throughput is one pixel per cycle; first pix_valid asserts 2 cycles after the start edge.
REQ-028 DRAIN -> DONE on the edge where the last beat transfers; done=1 from that edge.
REQ-029 Simultaneous FIFO push and pop in one cycle keep occupancy unchanged.
REQ-030 Address counter is 12 bits; it does not wrap within a frame.

Reset
REQ-031 reset asserted at any time, including mid-frame: state IDLE, FIFO empty, in-flight read discarded, counter 0.
REQ-032 Reset values: FB_CEN=1, FB_WEN=1, FB_A=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, sof=0, eol=0, busy=0, done=0.

Structure
REQ-033 Shared package sgde_pkg holds FB_DIM=64, FB_AW=12, PIX_W=12, BG_COLOR=12'hCF0 and the scanout state enumeration.
REQ-034 The 2-entry tagged FIFO is sub-module fb_rd_fifo; the FSM, read issue and gap counter stay in fb_scanout.

Verification
REQ-035 FB preloaded with Q[a]=a, start, pix_ready=1 -> 4096 beats with pix_data={pix_y,pix_x}, sof on beat 0 only, eol every 64th beat, done 1 cycle after beat 4095.
REQ-036 pix_ready toggling 1,0,1,0 -> 4096 beats with no loss or duplication, outputs stable during stalls, at most 2 reads outstanding.
REQ-037 pix_ready=0 for 20 cycles after start -> pix_valid=1 with pix_data=Q[0] held, exactly 2 reads issued, FB_CEN=1 thereafter until first transfer.
REQ-038 NUM_LINES=2, LINE_GAP=3 -> 128 beats, FB_CEN=1 for exactly 3 cycles after read of 12'h03F, done after beat 127.
REQ-039 reset pulse at beat 1000 -> next cycle pix_valid=0, FB_CEN=1, busy=0; a new start restarts at FB_A=0 with sof.
REQ-040 start pulsed during SCAN -> ignored, frame completes normally with 4096 beats; start in DONE clears done and begins a new frame.
